// File: rtl/fifo_wr_pkg.sv
// fifo_wr_pkg
//   Shared constants and types for the write side of the async FIFO path:
//   word/byte/lane geometry, the byte packer FSM state encoding, and a helper
//   that pads the unused upper lanes of a partial word.
package fifo_wr_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int IDX_W  = 2;

  // IDLE: no byte held. FILL: one to three bytes held in the accumulator.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } wr_state_e;

  // Replace every lane above last_lane with the pad byte.
  function automatic logic [WORD_W-1:0] fill_upper_lanes(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  last_lane,
    input logic [BYTE_W-1:0] pad
  );
    logic [WORD_W-1:0] w;
    w = word;
    for (int i = 0; i < LANES; i++) begin
      if (i > int'(last_lane)) begin
        w[i*BYTE_W +: BYTE_W] = pad;
      end else begin
        w[i*BYTE_W +: BYTE_W] = word[i*BYTE_W +: BYTE_W];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer
//   Packs an upstream byte stream little-endian into 32-bit words and pushes
//   them into the write port of a downstream async FIFO. A word completes on
//   its 4th byte or on a byte marked in_last (upper lanes padded). Completed
//   words wait in a single pending register until the FIFO accepts them.
// Ports:
//   clk_wr        write-domain clock
//   Rst           asynchronous active-high reset
//   en            global enable; low freezes all state
//   in_valid/in_data/in_last/in_ready   upstream byte handshake
//   fifo_full     FIFO FULL flag
//   wr_en/wr_data FIFO write strobe and word
//   words_pushed  number of words written (wraps)
module byte_packer
  import fifo_wr_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 16
) (
  input  logic              clk_wr,
  input  logic              Rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              fifo_full,
  output logic              wr_en,
  output logic [31:0]       wr_data,
  output logic [CNT_W-1:0]  words_pushed
);

  wr_state_e          state_q, state_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic               pend_valid_q, pend_valid_d;
  logic [WORD_W-1:0]  pend_data_q, pend_data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic               word_done;
  logic [WORD_W-1:0]  merged;

  // Handshake and FIFO strobe. A byte may be taken while a word is pending
  // as long as that word leaves on the same edge, so the pending register
  // is never overwritten.
  always_comb begin
    in_ready  = en && !(pend_valid_q && fifo_full);
    wr_en     = en && pend_valid_q && !fifo_full;
    wr_data   = pend_data_q;
    accept    = in_valid && in_ready;
    word_done = accept && (in_last || (byte_idx_q == 2'd3));
  end

  // Next-state: accumulator merge, pending register load/drain, counter, FSM.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    acc_d        = acc_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    cnt_d        = cnt_q;

    // In IDLE the accumulator is logically empty, so start from zero.
    if (state_q == ST_IDLE) begin
      merged = {WORD_W{1'b0}};
    end else begin
      merged = acc_q;
    end
    merged[{byte_idx_q, 3'b000} +: BYTE_W] = in_data;

    // Drain first; a word completing on the same edge reloads below.
    if (wr_en) begin
      pend_valid_d = 1'b0;
      cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pend_valid_d = pend_valid_q;
      cnt_d        = cnt_q;
    end

    if (word_done) begin
      pend_valid_d = 1'b1;
      pend_data_d  = fill_upper_lanes(merged, byte_idx_q, PAD_BYTE);
      acc_d        = {WORD_W{1'b0}};
      byte_idx_d   = 2'd0;
    end else if (accept) begin
      acc_d      = merged;
      byte_idx_d = byte_idx_q + 2'd1;
    end else begin
      acc_d      = acc_q;
      byte_idx_d = byte_idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && !in_last) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (word_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_wr or posedge Rst) begin
    if (Rst) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= 2'd0;
      acc_q        <= {WORD_W{1'b0}};
      pend_valid_q <= 1'b0;
      pend_data_q  <= {WORD_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      acc_q        <= acc_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign words_pushed = cnt_q;

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00, the fill value for unused byte lanes of a flushed partial word.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the pushed-word counter.
REQ-003 SHALL have port clk_wr  input  1  write-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global enable; when low, no byte is accepted and no word is pushed.
REQ-006 SHALL have port in_valid  input  1  the upstream byte is valid.
REQ-007 SHALL have port in_data  input  8  the upstream byte.
REQ-008 SHALL have port in_last  input  1  marks the final byte of a packet; the partial word is flushed.
REQ-009 SHALL have port in_ready  output  1  the block can accept a byte this cycle.
REQ-010 SHALL have port fifo_full  input  1  FULL flag from the downstream async FIFO.
REQ-011 SHALL have port wr_en  output  1  FIFO write strobe (to WR_EN).
REQ-012 SHALL have port wr_data  output  32  FIFO write word (to dataIn).
REQ-013 SHALL have port words_pushed  output  CNT_W  count of words written to the FIFO.

Function
REQ-014 SHALL accept a byte on a rising clk_wr edge when in_valid and in_ready are both 1.
REQ-015 SHALL pack bytes little-endian: the first byte of a word goes to [7:0] and the fourth to [31:24].
REQ-016 SHALL track a 2-bit lane index, byte_idx: 0 after reset, +1 per accepted byte, 0 after the 4th byte or after a byte with in_last=1.
REQ-017 SHALL keep FSM states IDLE (byte_idx=0, empty accumulator) and FILL (1-3 bytes held); a byte accepted in IDLE moves to FILL unless in_last=1; the 4th byte or an in_last byte returns to IDLE.
REQ-018 SHALL load a completed word into a single pending register (pend_valid, pend_data) on the same edge that accepts the completing byte.
REQ-019 SHALL set the unused upper lanes of a word completed by in_last to PAD_BYTE; in_last on the 4th byte adds no padding.
REQ-020 SHALL drive wr_en = en && pend_valid && !fifo_full combinationally.
REQ-021 SHALL drive wr_data = pend_data at all times.
REQ-022 SHALL clear pend_valid on an edge where wr_en=1, unless a new word completes on that edge, in which case the pending register reloads and pend_valid stays 1.
REQ-023 SHALL drive in_ready = en && !(pend_valid && fifo_full) combinationally.
REQ-024 SHALL sustain one byte per cycle with no input bubble while fifo_full=0.
REQ-025 SHALL write each word to the FIFO exactly once, with no loss or duplication, regardless of fifo_full toggling.
REQ-026 SHALL make wr_en go high in the cycle after the completing byte is accepted when fifo_full=0 (latency 1).
REQ-027 SHALL increment words_pushed by 1 on each edge with wr_en=1 and wrap modulo 2^CNT_W.
REQ-028 SHALL freeze all state while en=0, then resume exactly where it stopped.

Reset
REQ-029 SHALL clear byte_idx, the accumulator, pend_valid, pend_data and words_pushed to 0 while Rst=1, and enter IDLE, independent of clk_wr.
REQ-030 SHALL discard a partially accumulated word and any pending word when reset is asserted mid-packet.
REQ-031 SHALL drive wr_en=0 and wr_data=0 during reset; in_ready follows en.

Structure
REQ-032 SHALL place the word width (32), byte width (8), lane count (4) and the FSM state encodings in shared include file fifo_wr_pkg, also used by the FIFO-side top level.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL be verified by this scenario: en=1, fifo_full=0, bytes 11,22,33,44 on back-to-back cycles -> wr_en high for 1 cycle, one cycle after 44 is accepted; wr_data=32'h44332211; words_pushed=1.
REQ-035 SHALL be verified by this scenario: bytes AA,BB,CC with in_last on CC -> wr_data=32'h00CCBBAA; the next byte starts at lane 0.
REQ-036 SHALL be verified by this scenario: fifo_full=1, bytes 01..04 -> in_ready falls after 04, wr_en=0; release fifo_full -> one push of 32'h04030201, then in_ready=1.
REQ-037 SHALL be verified by this scenario: 8 bytes 01..08, fifo_full=0 -> in_ready stays 1 throughout; pushes 32'h04030201 then 32'h08070605; words_pushed=2.
REQ-038 SHALL be verified by this scenario: bytes 01,02, then a Rst pulse between clock edges, then bytes 05,06,07,08 -> a single push of 32'h08070605 and no push with 01 or 02.
REQ-039 SHALL be verified by this scenario: en=0 for 3 cycles between bytes 2 and 3 with in_valid=1 -> no byte accepted while en=0; the final word is unchanged, 32'h04030201.
